// File: rtl/ram_if.sv
// Bus bundle for the simple dual-port RAM.
// The master side drives the write port and the read request, and receives the read data.
interface ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] dir_w;
    logic              hab_w;
    logic [DATA_W-1:0] dat_w;
    logic [ADDR_W-1:0] dir_r;
    logic              hab_r;
    logic [DATA_W-1:0] dat_r;

    modport master (
        output dir_w, hab_w, dat_w, dir_r, hab_r,
        input  dat_r
    );

    modport slave (
        input  dir_w, hab_w, dat_w, dir_r, hab_r,
        output dat_r
    );
endinterface

// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
// Same-address read and write on one edge return the new data (write-first).
module ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic   clk,
    input  logic   rst,
    ram_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Contents start at zero and are deliberately left untouched by rst.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              wr_en;
    logic              rd_en;
    logic              bypass;
    logic [DATA_W-1:0] dat_r_d;
    logic [DATA_W-1:0] dat_r_q;

    always_comb begin
        wr_en   = bus.hab_w && !rst;
        rd_en   = bus.hab_r && !rst;
        bypass  = wr_en && rd_en && (bus.dir_w == bus.dir_r);
        dat_r_d = dat_r_q;
        if (rd_en) begin
            dat_r_d = bypass ? bus.dat_w : mem[bus.dir_r];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.dir_w] <= bus.dat_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_r_q <= '0;
        end else begin
            dat_r_q <= dat_r_d;
        end
    end

    assign bus.dat_r = dat_r_q;
endmodule

// File: tb/tb_ram.sv
// Directed bench for the dual-port RAM with hand-computed expected values.
module tb_ram;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic re, input logic [ADDR_W-1:0] ra);
        bus.hab_w = we;
        bus.dir_w = wa;
        bus.dat_w = wd;
        bus.hab_r = re;
        bus.dir_r = ra;
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);

        tick();
        tick();
        check("reset_state", bus.dat_r, 32'h0000_0000);

        rst = 1'b0;
        // Write 511, read port idle: dat_r must not move.
        drive(1'b1, 9'd511, 32'hAAAA_AAAA, 1'b0, 9'd0);
        tick();
        check("idle_read_after_write", bus.dat_r, 32'h0000_0000);

        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd511);
        tick();
        check("write_then_read_511", bus.dat_r, 32'hAAAA_AAAA);

        // Blocked write must not disturb 511.
        drive(1'b0, 9'd511, 32'hBBBB_BBBB, 1'b0, 9'd511);
        tick();
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd511);
        tick();
        check("blocked_write", bus.dat_r, 32'hAAAA_AAAA);

        drive(1'b0, 9'd0, 32'h0, 1'b0, 9'd0);
        tick();
        check("read_hold_1", bus.dat_r, 32'hAAAA_AAAA);
        tick();
        check("read_hold_2", bus.dat_r, 32'hAAAA_AAAA);

        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd100);
        tick();
        check("power_up_zero_100", bus.dat_r, 32'h0000_0000);

        // Same-address read and write on one edge.
        drive(1'b1, 9'd7, 32'h1234_5678, 1'b1, 9'd7);
        tick();
        check("rdw_bypass_7", bus.dat_r, 32'h1234_5678);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd7);
        tick();
        check("rdw_stored_7", bus.dat_r, 32'h1234_5678);

        // Different addresses on one edge: read sees old contents of its own address.
        drive(1'b1, 9'd7, 32'hDEAD_BEEF, 1'b1, 9'd511);
        tick();
        check("indep_read_511", bus.dat_r, 32'hAAAA_AAAA);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd7);
        tick();
        check("indep_write_7", bus.dat_r, 32'hDEAD_BEEF);

        // Boundary addresses.
        drive(1'b1, 9'd0, 32'h0000_0001, 1'b0, 9'd0);
        tick();
        drive(1'b1, 9'd511, 32'hFFFF_FFFF, 1'b0, 9'd0);
        tick();
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd0);
        tick();
        check("boundary_0", bus.dat_r, 32'h0000_0001);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd511);
        tick();
        check("boundary_511", bus.dat_r, 32'hFFFF_FFFF);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd256);
        tick();
        check("no_alias_256", bus.dat_r, 32'h0000_0000);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd255);
        tick();
        check("no_alias_255", bus.dat_r, 32'h0000_0000);

        // Reset mid-operation with write and read requested on the same edge.
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd511);
        tick();
        check("pre_reset_nonzero", bus.dat_r, 32'hFFFF_FFFF);
        rst = 1'b1;
        drive(1'b1, 9'd511, 32'h5555_5555, 1'b1, 9'd511);
        tick();
        check("reset_clears_dat_r", bus.dat_r, 32'h0000_0000);
        rst = 1'b0;
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd511);
        tick();
        check("reset_blocks_write", bus.dat_r, 32'hFFFF_FFFF);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd0);
        tick();
        check("reset_keeps_mem_0", bus.dat_r, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
